// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipe_hazard_ctrl.
//   master : pipeline side; drives the ID/EX/MEM hazard inputs and receives
//            the write enables, flush/bubble controls and status.
//   slave  : controller side (pipe_hazard_ctrl).
// Signals:
//   id_rgS1_index, id_rgS2_index, id_uses_rs2 : source operands of the ID instruction
//   ex_rgD_index, ex_write_reg, ex_ld_ins     : destination/control of the ID/EX instruction
//   ex_br_taken                               : branch in EX resolved taken
//   mem_req, mem_ready                        : MEM stage access handshake
//   pc_we .. mem_wb_we                        : PC and pipeline-register write enables
//   if_id_flush, id_ex_bubble                 : NOP insertion controls
//   state, mem_timeout, stall_cycles          : status
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rgS1_index;
  logic [4:0]  id_rgS2_index;
  logic        id_uses_rs2;
  logic [4:0]  ex_rgD_index;
  logic        ex_write_reg;
  logic        ex_ld_ins;
  logic        ex_br_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output id_rgS1_index, id_rgS2_index, id_uses_rs2,
    output ex_rgD_index, ex_write_reg, ex_ld_ins, ex_br_taken,
    output mem_req, mem_ready,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    input  if_id_flush, id_ex_bubble,
    input  state, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rgS1_index, id_rgS2_index, id_uses_rs2,
    input  ex_rgD_index, ex_write_reg, ex_ld_ins, ex_br_taken,
    input  mem_req, mem_ready,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
    output if_id_flush, id_ex_bubble,
    output state, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage pipeline.
// Resolves, in priority order: timeout error > memory stall > taken branch >
// load-use hazard > normal flow. All controls are combinational from the
// current FSM state and inputs; the FSM only tracks outstanding memory waits.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   hz    : hazard-control bus (slave side), see pipe_hazard_ctrl_if
// Parameter:
//   TIMEOUT : max MEM_WAIT cycles (8-bit wait counter) before entering ERROR
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic memstall;
  logic load_use;
  logic pc_we;

  assign memstall = hz.mem_req & ~hz.mem_ready;

  // Register 0 is hardwired zero, so a write to it can never create a hazard.
  assign load_use = hz.ex_ld_ins & hz.ex_write_reg & (hz.ex_rgD_index != 5'd0) &
                    ((hz.ex_rgD_index == hz.id_rgS1_index) |
                     (hz.id_uses_rs2 & (hz.ex_rgD_index == hz.id_rgS2_index)));

  // Control outputs
  always_comb begin
    pc_we           = 1'b1;
    hz.if_id_we     = 1'b1;
    hz.id_ex_we     = 1'b1;
    hz.ex_mem_we    = 1'b1;
    hz.mem_wb_we    = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    if (state_q == StError || memstall) begin
      // Freeze the whole pipeline.
      pc_we        = 1'b0;
      hz.if_id_we  = 1'b0;
      hz.id_ex_we  = 1'b0;
      hz.ex_mem_we = 1'b0;
      hz.mem_wb_we = 1'b0;
    end else if (hz.ex_br_taken) begin
      // Squash the two wrong-path instructions in IF/ID and ID/EX.
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      // Hold IF and ID; the bubble clears ex_ld_ins so this lasts one cycle.
      pc_we           = 1'b0;
      hz.if_id_we     = 1'b0;
      hz.id_ex_bubble = 1'b1;
    end
  end

  assign hz.pc_we = pc_we;

  // FSM next state, wait counter and sticky timeout
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      StRun: begin
        if (memstall) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd0;
        end
      end
      StMemWait: begin
        if (hz.mem_ready) begin
          state_d = StRun;
        end else if (wait_cnt_q == TimeoutVal) begin
          state_d       = StError;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StError: begin
        // Only reset leaves ERROR.
        state_d       = StError;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_we && stall_cycles_q != 16'hFFFF) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StRun;
      wait_cnt_q     <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.state        = state_q;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT overridden to 6).
module tb_pipe_hazard_ctrl;
  localparam int unsigned Tmo = 6;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.TIMEOUT(Tmo)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hz.id_rgS1_index = 5'd0;
    hz.id_rgS2_index = 5'd0;
    hz.id_uses_rs2   = 1'b0;
    hz.ex_rgD_index  = 5'd0;
    hz.ex_write_reg  = 1'b0;
    hz.ex_ld_ins     = 1'b0;
    hz.ex_br_taken   = 1'b0;
    hz.mem_req       = 1'b0;
    hz.mem_ready     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
  function automatic logic [31:0] ctl();
    return {25'd0, hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.ex_mem_we, hz.mem_wb_we,
            hz.if_id_flush, hz.id_ex_bubble};
  endfunction

  localparam logic [31:0] CtlNormal = 32'b11111_0_0;
  localparam logic [31:0] CtlFreeze = 32'b00000_0_0;
  localparam logic [31:0] CtlBranch = 32'b11111_1_1;
  localparam logic [31:0] CtlLoadUs = 32'b00111_0_1;

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    #12;
    check("rst_state", 32'(hz.state), 32'd0);
    check("rst_timeout", 32'(hz.mem_timeout), 32'd0);
    check("rst_stalls", 32'(hz.stall_cycles), 32'd0);
    check("rst_ctl_normal", ctl(), CtlNormal);
    hz.ex_br_taken = 1'b1;
    #1;
    check("rst_ctl_branch", ctl(), CtlBranch);
    idle();
    tick();
    reset = 1'b0;
    tick();

    // Load-use on rs1: exactly one stall cycle
    hz.ex_ld_ins = 1'b1; hz.ex_write_reg = 1'b1;
    hz.ex_rgD_index = 5'd5; hz.id_rgS1_index = 5'd5;
    #1;
    check("lu_rs1_ctl", ctl(), CtlLoadUs);
    tick();
    hz.ex_ld_ins = 1'b0; // bubble cleared the load
    #1;
    check("lu_after_ctl", ctl(), CtlNormal);
    check("lu_stalls", 32'(hz.stall_cycles), 32'd1);
    tick();
    check("lu_stalls_hold", 32'(hz.stall_cycles), 32'd1);

    // Non-hazard variants (combinational only)
    idle();
    hz.ex_ld_ins = 1'b1; hz.ex_write_reg = 1'b1;
    hz.ex_rgD_index = 5'd0; hz.id_rgS1_index = 5'd0;
    #1;
    check("lu_r0_nostall", ctl(), CtlNormal);
    hz.ex_rgD_index = 5'd7; hz.id_rgS1_index = 5'd3; hz.id_rgS2_index = 5'd7;
    hz.id_uses_rs2 = 1'b0;
    #1;
    check("lu_rs2_unused", ctl(), CtlNormal);
    hz.id_uses_rs2 = 1'b1;
    #1;
    check("lu_rs2_used", ctl(), CtlLoadUs);
    hz.ex_write_reg = 1'b0;
    #1;
    check("lu_nowrite", ctl(), CtlNormal);
    hz.ex_write_reg = 1'b1;
    hz.ex_br_taken = 1'b1;
    #1;
    check("branch_over_lu", ctl(), CtlBranch);
    idle();
    tick();
    check("stalls_after_comb", 32'(hz.stall_cycles), 32'd1);

    // Memory stall of 3 cycles then ready
    hz.mem_req = 1'b1;
    #1;
    check("ms_c1_ctl", ctl(), CtlFreeze);
    check("ms_c1_state", 32'(hz.state), 32'd0);
    tick();
    hz.ex_br_taken = 1'b1;
    #1;
    check("ms_c2_ctl_branch", ctl(), CtlFreeze);
    check("ms_c2_state", 32'(hz.state), 32'd1);
    tick();
    hz.ex_br_taken = 1'b0;
    #1;
    check("ms_c3_ctl", ctl(), CtlFreeze);
    tick();
    hz.mem_ready = 1'b1;
    #1;
    check("ms_ready_ctl", ctl(), CtlNormal);
    check("ms_ready_state", 32'(hz.state), 32'd1);
    tick();
    idle();
    #1;
    check("ms_done_state", 32'(hz.state), 32'd0);
    check("ms_done_ctl", ctl(), CtlNormal);
    check("ms_stalls", 32'(hz.stall_cycles), 32'd4);

    // Timeout: 1 RUN cycle + (Tmo+1) MEM_WAIT cycles, then ERROR
    hz.mem_req = 1'b1;
    for (int i = 0; i < Tmo + 1; i++) tick();
    check("to_pre_state", 32'(hz.state), 32'd1);
    check("to_pre_flag", 32'(hz.mem_timeout), 32'd0);
    tick();
    check("to_state", 32'(hz.state), 32'd2);
    check("to_flag", 32'(hz.mem_timeout), 32'd1);
    check("to_stalls", 32'(hz.stall_cycles), 32'd12);
    hz.mem_req = 1'b0; hz.mem_ready = 1'b1; hz.ex_br_taken = 1'b1;
    #1;
    check("err_ctl", ctl(), CtlFreeze);
    tick();
    check("err_sticky_state", 32'(hz.state), 32'd2);
    check("err_sticky_flag", 32'(hz.mem_timeout), 32'd1);
    check("err_stalls", 32'(hz.stall_cycles), 32'd13);
    idle();

    // Saturation of stall_cycles while frozen in ERROR
    for (int i = 0; i < 65530; i++) tick();
    check("stalls_saturate", 32'(hz.stall_cycles), 32'h0000_FFFF);

    // Asynchronous reset out of ERROR, mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check("rst_err_state", 32'(hz.state), 32'd0);
    check("rst_err_flag", 32'(hz.mem_timeout), 32'd0);
    check("rst_err_stalls", 32'(hz.stall_cycles), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Asynchronous reset mid MEM_WAIT
    hz.mem_req = 1'b1;
    tick();
    tick();
    check("mw_state", 32'(hz.state), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mw_state", 32'(hz.state), 32'd0);
    check("rst_mw_stalls", 32'(hz.stall_cycles), 32'd0);
    check("rst_mw_ctl", ctl(), CtlFreeze);
    idle();
    tick();
    reset = 1'b0;
    tick();
    check("final_ctl", ctl(), CtlNormal);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, max MEM_WAIT cycles before error.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 id_rgS1_index  in  5  source-1 register index of the instruction in ID.
REQ-005 id_rgS2_index  in  5  source-2 register index of the instruction in ID.
REQ-006 id_uses_rs2  in  1  instruction in ID reads source 2.
REQ-007 ex_rgD_index  in  5  destination index held in ID/EX.
REQ-008 ex_write_reg  in  1  ID/EX control bit 3 (write to register).
REQ-009 ex_ld_ins  in  1  ID/EX control bit 5 (load instruction).
REQ-010 ex_br_taken  in  1  branch in EX resolved taken.
REQ-011 mem_req  in  1  MEM stage is accessing memory this cycle.
REQ-012 mem_ready  in  1  memory completes the access this cycle.
REQ-013 pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  write enables for PC and pipeline registers.
REQ-014 if_id_flush  out  1  IF/ID captures a NOP on the next edge.
REQ-015 id_ex_bubble  out  1  ID/EX captures all control bits as zero on the next edge.
REQ-016 state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR.
REQ-017 mem_timeout  out  1  sticky memory timeout flag.
REQ-018 stall_cycles  out  16  count of cycles with pc_we low.

Function
REQ-019 The block SHALL compute all enables, flush and bubble combinationally from the current state and inputs, with zero-cycle latency.
REQ-020 Memory stall condition memstall = mem_req AND NOT mem_ready; the block SHALL drive all five enables low, and flush and bubble low, in any cycle where memstall holds.
REQ-021 RUN -> MEM_WAIT on a clock edge with memstall; MEM_WAIT -> RUN on an edge with mem_ready high; the cycle with mem_ready high SHALL have all enables high.
REQ-022 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; MEM_WAIT -> ERROR when the counter equals TIMEOUT and mem_ready is low.
REQ-023 In ERROR, all enables SHALL be low and mem_timeout high; ERROR exits only by reset.
REQ-024 Branch, when not in a memory stall and ex_br_taken is high: if_id_flush=1, id_ex_bubble=1, all enables high.
REQ-025 Load-use hazard = ex_ld_ins AND ex_write_reg AND ex_rgD_index!=0 AND (ex_rgD_index==id_rgS1_index OR (id_uses_rs2 AND ex_rgD_index==id_rgS2_index)).
REQ-026 On a load-use hazard with no memstall and no branch: pc_we=0, if_id_we=0, id_ex_we=1, id_ex_bubble=1, ex_mem_we=1, mem_wb_we=1; the stall lasts exactly one cycle because the bubble clears ex_ld_ins.
REQ-027 Priority: ERROR > memstall > branch > load-use > normal (all enables 1, flush and bubble 0).
REQ-028 stall_cycles SHALL increment on each edge where pc_we is low and saturate at 0xFFFF.
REQ-029 A register index of 0 SHALL never produce a hazard.

Reset
REQ-030 Reset SHALL asynchronously force state=RUN, the wait counter to 0, mem_timeout=0 and stall_cycles=0, including mid-MEM_WAIT and in ERROR.
REQ-031 During reset, outputs SHALL follow REQ-027 evaluated with state=RUN.

Verification
REQ-032 Load at ex_rgD_index=5, id_rgS1_index=5 -> one cycle with pc_we=0, if_id_we=0 and id_ex_bubble=1, then normal operation; stall_cycles=1.
REQ-033 Same as REQ-032 but with ex_rgD_index=0, or with a rs2 match and id_uses_rs2=0 -> no stall.
REQ-034 Hold mem_req=1 and mem_ready=0 for 3 cycles, then mem_ready=1 -> enables low for 3 cycles, state=1, and enables high and state=0 after the ready cycle; stall_cycles=3.
REQ-035 ex_br_taken together with a load-use hazard -> flush=1, bubble=1, all enables high, no stall.
REQ-036 Hold mem_req=1 and mem_ready=0 for more than TIMEOUT+1 cycles -> state=2 and mem_timeout=1, persisting after mem_ready rises; reset asserted mid-wait -> state=0 immediately.
